window_serializer: RTL and testbench

WINDOW_SERIALIZER -- requirements
Module: window_serializer

---
 rtl/dense_pkg.sv | 14 +
 rtl/window_serializer_if.sv | 42 ++++
 rtl/sr_beat_cnt.sv | 32 +++
 rtl/window_serializer.sv | 116 +++++++++++
 tb/tb_window_serializer.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the dense window blocks.
//   BYTE_W        : width of one window byte
//   dense_state_e : serializer FSM encoding (IDLE = no window held,
//                   SHIFT = window held with bytes still to emit)
package dense_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } dense_state_e;

endpackage

// File: rtl/window_serializer_if.sv
// Bus bundle for window_serializer: a parallel window load channel and a
// byte-wide serial output channel.
//   p_window_in : parallel window, byte i = bits [8i+7:8i]
//   load_valid  : p_window_in is valid this cycle
//   load_ready  : serializer can take a window this cycle
//   shift_out   : current serial byte
//   out_valid   : shift_out holds a valid byte
//   out_ready   : downstream takes shift_out this cycle
//   out_last    : shift_out is byte 0, the final byte of the window
//
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holding valid=1 keeps
// its data stable until that edge; ready may change freely and valid never
// waits on ready.
// master = the side that feeds windows and consumes bytes; slave = the
// serializer.
interface window_serializer_if #(
    parameter int P_SR_DEPTH  = 3,
    parameter int NUM_SR_ROWS = 3
);

    localparam int N = P_SR_DEPTH * NUM_SR_ROWS;

    logic [dense_pkg::BYTE_W*N-1:0] p_window_in;
    logic                           load_valid;
    logic                           load_ready;
    logic [dense_pkg::BYTE_W-1:0]   shift_out;
    logic                           out_valid;
    logic                           out_ready;
    logic                           out_last;

    modport master (
        output p_window_in, load_valid, out_ready,
        input  load_ready, shift_out, out_valid, out_last
    );

    modport slave (
        input  p_window_in, load_valid, out_ready,
        output load_ready, shift_out, out_valid, out_last
    );

endinterface

// File: rtl/sr_beat_cnt.sv
// Byte index down-counter for the window serializer.
//   clock, reset : clock and asynchronous active-low reset
//   load         : set the index to N-1 (a new window was accepted)
//   dec          : step the index down by one (a non-final byte was taken)
//   idx          : index of the byte currently presented
//   is_last      : idx is 0
// The counter saturates at 0, so a stray dec never wraps it around.
module sr_beat_cnt #(
    parameter  int N     = 9,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    output logic [IDX_W-1:0] idx,
    output logic             is_last
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx <= '0;
        end else if (load) begin
            idx <= IDX_W'(N - 1);
        end else if (dec && (idx != '0)) begin
            idx <= idx - 1'b1;
        end
    end

    assign is_last = (idx == '0);

endmodule

// File: rtl/window_serializer.sv
// Window serializer: captures a parallel window of N = P_SR_DEPTH *
// NUM_SR_ROWS bytes and emits it one byte per handshake, oldest first
// (byte N-1 down to byte 0), flagging byte 0 with out_last.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : window_serializer_if slave (load and output channels)
//   state_dbg    : current FSM state
// shift_out, out_valid and out_last all come straight from flops. A new
// window can be taken on the same edge the last byte of the previous one
// leaves, so back-to-back windows stream without a bubble.
module window_serializer
    import dense_pkg::*;
#(
    parameter int P_SR_DEPTH  = 3,
    parameter int NUM_SR_ROWS = 3
) (
    input  logic                clock,
    input  logic                reset,
    window_serializer_if.slave  bus,
    output dense_state_e        state_dbg
);

    localparam int N     = P_SR_DEPTH * NUM_SR_ROWS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    dense_state_e            state_q, state_d;
    logic [BYTE_W*N-1:0]     cap_q;
    logic [BYTE_W-1:0]       shift_q;
    logic                    valid_q;
    logic                    last_q;

    logic                    beat;
    logic                    last_beat;
    logic                    accept;
    logic [IDX_W-1:0]        idx;
    logic                    is_last;
    logic [IDX_W-1:0]        nxt_idx;
    logic [BYTE_W-1:0]       nxt_byte;

    assign beat      = valid_q & bus.out_ready;
    assign last_beat = beat & last_q;

    // Ready while empty, or while the final byte is leaving this edge.
    assign bus.load_ready = (state_q == ST_IDLE) | last_beat;
    assign accept         = bus.load_valid & bus.load_ready;

    sr_beat_cnt #(.N(N)) u_beat_cnt (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .dec     (beat & ~is_last),
        .idx     (idx),
        .is_last (is_last)
    );

    // Byte that follows the one currently presented.
    assign nxt_idx = idx - 1'b1;

    always_comb begin
        nxt_byte = '0;
        for (int i = 0; i < N; i++) begin
            if (nxt_idx == IDX_W'(i)) begin
                nxt_byte = cap_q[BYTE_W*i +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_beat && !accept) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            // The oldest byte goes out first, straight from the input.
            cap_q   <= bus.p_window_in;
            shift_q <= bus.p_window_in[BYTE_W*(N-1) +: BYTE_W];
            valid_q <= 1'b1;
            last_q  <= (N == 1);
        end else if (beat) begin
            if (last_q) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                shift_q <= nxt_byte;
                last_q  <= (nxt_idx == '0);
            end
        end
    end

    assign bus.shift_out = shift_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_window_serializer.sv
// Directed bench for window_serializer: a 3x3 instance for the main
// scenarios and a 1x1 instance for the single-byte window case.
module tb_window_serializer;
    import dense_pkg::*;

    localparam int N = 9;
    localparam int W = 8 * N;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    window_serializer_if #(.P_SR_DEPTH(3), .NUM_SR_ROWS(3)) bus ();
    window_serializer_if #(.P_SR_DEPTH(1), .NUM_SR_ROWS(1)) bus1 ();
    dense_state_e st, st1;

    window_serializer #(.P_SR_DEPTH(3), .NUM_SR_ROWS(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (st)
    );

    window_serializer #(.P_SR_DEPTH(1), .NUM_SR_ROWS(1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus1),
        .state_dbg (st1)
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Window whose bytes come out as first, first+1, ..., first+N-1.
    function automatic logic [W-1:0] win_seq(input logic [7:0] first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) w[8*i +: 8] = first + 8'(N - 1 - i);
        return w;
    endfunction

    task automatic load_window(input logic [W-1:0] w);
        int g;
        bus.p_window_in = w;
        bus.load_valid  = 1'b1;
        g = 0;
        while (!bus.load_ready && g < 50) begin
            tick();
            g++;
        end
        total++;
        if (bus.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_wait got load_ready=%b exp=1", bus.load_ready);
        end
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.shift_out !== 8'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%0h l=%b exp v=0 d=0 l=0",
                     bus.out_valid, bus.shift_out, bus.out_last);
        end
        total++;
        if (st !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state got %0d exp %0d", st, ST_IDLE);
        end
        total++;
        if (bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_n1_valid got %b exp 0", bus1.out_valid);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        total++;
        if (bus.load_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_load_ready got %b exp 1", bus.load_ready);
        end
    endtask

    task automatic test_basic;
        logic [W-1:0] w, sr;
        w  = win_seq(8'd0);
        sr = '0;
        for (int k = 0; k < N; k++) exp_q.push_back(8'(k));
        bus.out_ready = 1'b1;
        load_window(w);
        for (int k = 0; k < N; k++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.shift_out !== exp_q[0]) begin
                bad++;
                $display("FAIL basic_byte k=%0d got v=%b d=%0h exp v=1 d=%0h",
                         k, bus.out_valid, bus.shift_out, exp_q[0]);
            end
            total++;
            if (bus.out_last !== (k == N - 1) || bus.load_ready !== (k == N - 1)) begin
                bad++;
                $display("FAIL basic_last k=%0d got last=%b ready=%b exp %b",
                         k, bus.out_last, bus.load_ready, (k == N - 1));
            end
            void'(exp_q.pop_front());
            sr = {sr[W-9:0], bus.shift_out};
            tick();
        end
        total++;
        if (bus.out_valid !== 1'b0 || st !== ST_IDLE) begin
            bad++;
            $display("FAIL basic_idle got v=%b st=%0d exp v=0 st=0", bus.out_valid, st);
        end
        total++;
        if (sr !== w) begin
            bad++;
            $display("FAIL round_trip got %h exp %h", sr, w);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        logic       held_last, have_held;
        int         c;
        have_held = 1'b0;
        held      = '0;
        held_last = 1'b0;
        for (int k = 0; k < N; k++) exp_q.push_back(8'hA0 + 8'(k));
        load_window(win_seq(8'hA0));
        c = 0;
        while (exp_q.size() > 0 && c < 60) begin
            bus.out_ready = (c % 3 == 0);
            if (have_held) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.shift_out !== held || bus.out_last !== held_last) begin
                    bad++;
                    $display("FAIL bp_stable c=%0d got v=%b d=%0h l=%b exp v=1 d=%0h l=%b",
                             c, bus.out_valid, bus.shift_out, bus.out_last, held, held_last);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.shift_out !== exp_q[0] || bus.out_last !== (exp_q.size() == 1)) begin
                    bad++;
                    $display("FAIL bp_byte c=%0d got d=%0h l=%b exp d=%0h l=%b",
                             c, bus.shift_out, bus.out_last, exp_q[0], (exp_q.size() == 1));
                end
                void'(exp_q.pop_front());
                have_held = 1'b0;
            end else if (bus.out_valid) begin
                held      = bus.shift_out;
                held_last = bus.out_last;
                have_held = 1'b1;
            end
            tick();
            c++;
        end
        bus.out_ready = 1'b1;
        total++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_done got left=%0d v=%b exp left=0 v=0", exp_q.size(), bus.out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        logic is_last;
        bus.out_ready   = 1'b1;
        bus.p_window_in = win_seq(8'd0);
        bus.load_valid  = 1'b1;
        tick();
        bus.p_window_in = win_seq(8'd9);
        for (int k = 0; k < 2 * N; k++) begin
            is_last = (k == N - 1) || (k == 2 * N - 1);
            total++;
            if (bus.out_valid !== 1'b1 || bus.shift_out !== 8'(k)) begin
                bad++;
                $display("FAIL b2b_byte k=%0d got v=%b d=%0h exp v=1 d=%0h",
                         k, bus.out_valid, bus.shift_out, k);
            end
            total++;
            if (bus.out_last !== is_last || bus.load_ready !== is_last) begin
                bad++;
                $display("FAIL b2b_last k=%0d got last=%b ready=%b exp %b",
                         k, bus.out_last, bus.load_ready, is_last);
            end
            if (k == 2 * N - 1) bus.load_valid = 1'b0;
            tick();
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_mid_reset;
        bus.out_ready = 1'b1;
        load_window(win_seq(8'd0));
        for (int k = 0; k < 4; k++) begin
            total++;
            if (bus.shift_out !== 8'(k)) begin
                bad++;
                $display("FAIL mr_pre k=%0d got %0h exp %0h", k, bus.shift_out, k);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.shift_out !== 8'd0 || bus.out_last !== 1'b0 || st !== ST_IDLE) begin
            bad++;
            $display("FAIL mr_async got v=%b d=%0h l=%b st=%0d exp all 0",
                     bus.out_valid, bus.shift_out, bus.out_last, st);
        end
        #3 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL mr_quiet k=%0d got v=%b exp 0", k, bus.out_valid);
            end
        end
        load_window(win_seq(8'h50));
        for (int k = 0; k < N; k++) begin
            total++;
            if (bus.out_valid !== 1'b1 || bus.shift_out !== 8'h50 + 8'(k)) begin
                bad++;
                $display("FAIL mr_reload k=%0d got v=%b d=%0h exp v=1 d=%0h",
                         k, bus.out_valid, bus.shift_out, 8'h50 + 8'(k));
            end
            tick();
        end
    endtask

    task automatic test_ignored_load;
        bus.out_ready = 1'b1;
        load_window(win_seq(8'hA0));
        for (int k = 0; k < N; k++) begin
            if (k == 3) begin
                bus.p_window_in = win_seq(8'hB0);
                bus.load_valid  = 1'b1;
            end
            if (k == 5) bus.load_valid = 1'b0;
            total++;
            if (bus.shift_out !== 8'hA0 + 8'(k) || bus.load_ready !== (k == N - 1)) begin
                bad++;
                $display("FAIL ign_byte k=%0d got d=%0h ready=%b exp d=%0h ready=%b",
                         k, bus.shift_out, bus.load_ready, 8'hA0 + 8'(k), (k == N - 1));
            end
            tick();
        end
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle got v=%b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_n1;
        logic [7:0] seq [3];
        seq[0] = 8'h11;
        seq[1] = 8'h22;
        seq[2] = 8'h33;
        bus1.out_ready   = 1'b1;
        bus1.p_window_in = seq[0];
        bus1.load_valid  = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus1.out_valid !== 1'b1 || bus1.shift_out !== seq[k] ||
                bus1.out_last !== 1'b1 || bus1.load_ready !== 1'b1) begin
                bad++;
                $display("FAIL n1_byte k=%0d got v=%b d=%0h l=%b r=%b exp v=1 d=%0h l=1 r=1",
                         k, bus1.out_valid, bus1.shift_out, bus1.out_last, bus1.load_ready, seq[k]);
            end
            if (k < 2) bus1.p_window_in = seq[k+1];
            else       bus1.load_valid  = 1'b0;
            tick();
        end
        total++;
        if (bus1.out_valid !== 1'b0 || st1 !== ST_IDLE) begin
            bad++;
            $display("FAIL n1_idle got v=%b st=%0d exp v=0 st=0", bus1.out_valid, st1);
        end
    endtask

    initial begin
        bus.p_window_in  = '0;
        bus.load_valid   = 1'b0;
        bus.out_ready    = 1'b0;
        bus1.p_window_in = '0;
        bus1.load_valid  = 1'b0;
        bus1.out_ready   = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_ignored_load();
        test_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
